// File: rtl/nf_reset_pkg.sv
// Shared definitions for the NIC reset sequencer: state encoding, reset cause
// codes and default timing parameters.
package nf_reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_IC     = 3'd2,
    ST_REL_PERIPH = 3'd3,
    ST_REL_CORE   = 3'd4,
    ST_RUN        = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_SW   = 2'b01,
    CAUSE_LOCK = 2'b10
  } rst_cause_t;

  localparam int HOLD_CYCLES_DEF  = 400;
  localparam int STAGE_GAP_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF = 65535;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/nf_reset_stage_cnt.sv
// Cycle counter with clear, terminal-count flag and optional saturation,
// shared by the hold, lock-wait and stage-gap timing of the reset sequencer.
module nf_reset_stage_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         sat,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count == limit);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !(sat && done))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/nf_reset_sequencer.sv
// Ordered reset release (interconnect, peripherals, core) with software and
// lock-loss re-entry. Optional event counter: NF_RESET_SEQ_EVENT_CNT_EN.
module nf_reset_sequencer
  import nf_reset_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP    = STAGE_GAP_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       axis_aclk,
  input  logic       axis_resetn,
  input  logic       clk_locked,
  input  logic       sw_rst_req,
  output logic       interconnect_resetn,
  output logic       periph_resetn,
  output logic       core_resetn,
  output logic       rst_done,
  output logic       lock_timeout,
  output logic [1:0] rst_cause,
  output logic [2:0] seq_state
`ifdef NF_RESET_SEQ_EVENT_CNT_EN
  , output logic [15:0] rst_event_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'(STAGE_GAP - 1);

  seq_state_t       state_q;
  rst_cause_t       cause_q;
  logic             lock_loss;
  logic             restart;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_sat;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_limit;

  assign lock_loss = !clk_locked &&
                     (state_q inside {ST_REL_IC, ST_REL_PERIPH, ST_REL_CORE, ST_RUN});
  assign restart   = sw_rst_req || lock_loss;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_sat   = 1'b0;
    cnt_limit = STAGE_LIM;
    if (restart) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          cnt_limit = HOLD_LIM;
          cnt_clr   = cnt_done;
          cnt_en    = 1'b1;
        end
        ST_WAIT_LOCK: begin
          cnt_limit = LOCK_LIM;
          cnt_sat   = 1'b1;
          cnt_clr   = clk_locked;
          cnt_en    = 1'b1;
        end
        ST_REL_IC, ST_REL_PERIPH, ST_REL_CORE: begin
          cnt_clr = cnt_done;
          cnt_en  = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  nf_reset_stage_cnt #(.W(CNT_W)) u_cnt (
    .clk   (axis_aclk),
    .rst_n (axis_resetn),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .sat   (cnt_sat),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q             <= ST_HOLD;
      cause_q             <= CAUSE_POR;
      interconnect_resetn <= 1'b0;
      periph_resetn       <= 1'b0;
      core_resetn         <= 1'b0;
      rst_done            <= 1'b0;
      lock_timeout        <= 1'b0;
    end else if (restart) begin
      // All domains drop together; lock loss outranks a coincident request.
      state_q             <= ST_HOLD;
      cause_q             <= lock_loss ? CAUSE_LOCK : CAUSE_SW;
      interconnect_resetn <= 1'b0;
      periph_resetn       <= 1'b0;
      core_resetn         <= 1'b0;
      rst_done            <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD:
          if (cnt_done) state_q <= ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (clk_locked) begin
            state_q             <= ST_REL_IC;
            interconnect_resetn <= 1'b1;
          end else if (cnt_done) begin
            lock_timeout <= 1'b1;
          end
        ST_REL_IC:
          if (cnt_done) begin
            state_q       <= ST_REL_PERIPH;
            periph_resetn <= 1'b1;
          end
        ST_REL_PERIPH:
          if (cnt_done) state_q <= ST_REL_CORE;
        ST_REL_CORE: begin
          core_resetn <= 1'b1;
          if (cnt_done) state_q <= ST_RUN;
        end
        default:
          rst_done <= 1'b1;
      endcase
    end
  end

  assign rst_cause = cause_q;
  assign seq_state = state_q;

`ifdef NF_RESET_SEQ_EVENT_CNT_EN
  logic [15:0] event_q;

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn)
      event_q <= '0;
    else if (restart && state_q != ST_HOLD && event_q != 16'hFFFF)
      event_q <= event_q + 1'b1;
  end

  assign rst_event_cnt = event_q;
`endif

endmodule
